// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential shift-add-3 (double-dabble) binary-to-BCD converter. Takes one
//   unsigned binary value per valid/ready handshake and, IN_W+1 edges later,
//   updates four registered BCD digits together with a one-cycle out_valid
//   pulse. The result is held between conversions so a downstream display
//   never flickers.
//
//   Only four decimal digits are kept, so the default build gives
//   bcd = bin_in mod 10000 and ovf stays 0.
//   Optional macro BCD_SATURATE_EN: inputs above 9999 yield bcd = 16'h9999
//   and ovf = 1 instead of wrapping.
//
// Parameters
//   IN_W   binary input width, 4..14
//   CNT_W  shift counter width, 2**CNT_W > IN_W
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   in_valid   bin_in is valid this cycle
//   bin_in     unsigned binary value to convert
//   in_ready   converter idle; handshake = in_valid && in_ready at posedge
//   busy       conversion in progress
//   out_valid  one-cycle pulse, bcd/ovf updated this cycle
//   bcd        {thousands, hundreds, tens, ones}, held until next out_valid
//   ovf        input exceeded 9999 (saturating build only, else 0)
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int IN_W  = 14,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [IN_W-1:0] bin_in,
    output logic            in_ready,
    output logic            busy,
    output logic            out_valid,
    output logic [15:0]     bcd,
    output logic            ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IN_W-1:0] bin_reg;
    logic [15:0]     scratch;
    logic [15:0]     scratch_adj;
    logic [CNT_W-1:0] cnt;
    logic            last_shift;

    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign last_shift = (cnt == CNT_W'(IN_W - 1));

    // Add-3 correction applied before each shift. A digit never exceeds 9
    // here, so the corrected value (at most 12) still fits in four bits.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef BCD_SATURATE_EN
    logic sat_pending;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_reg   <= '0;
            scratch   <= '0;
            cnt       <= '0;
            bcd       <= '0;
            out_valid <= 1'b0;
`ifdef BCD_SATURATE_EN
            sat_pending <= 1'b0;
            ovf         <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_reg <= bin_in;
                        scratch <= '0;
                        cnt     <= '0;
`ifdef BCD_SATURATE_EN
                        sat_pending <= (32'(bin_in) > 32'd9999);
`endif
                    end
                end
                SHIFT: begin
                    // Bit carried out of the thousands digit is dropped.
                    scratch <= {scratch_adj[14:0], bin_reg[IN_W-1]};
                    bin_reg <= {bin_reg[IN_W-2:0], 1'b0};
                    cnt     <= cnt + CNT_W'(1);
                end
                DONE: begin
                    out_valid <= 1'b1;
`ifdef BCD_SATURATE_EN
                    bcd <= sat_pending ? 16'h9999 : scratch;
                    ovf <= sat_pending;
`else
                    bcd <= scratch;
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef BCD_SATURATE_EN
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Self-checking bench for bin2bcd_seq: reset state, a table of directed
//   values, random values against a decimal-arithmetic model, and hand-written
//   sequences for back-to-back, ignored-while-busy and reset-abort cases.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    localparam int IN_W  = 14;
    localparam int CNT_W = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [IN_W-1:0] bin_in;
    logic            in_ready;
    logic            busy;
    logic            out_valid;
    logic [15:0]     bcd;
    logic            ovf;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    bin2bcd_seq #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .bin_in    (bin_in),
        .in_ready  (in_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .bcd       (bcd),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          val;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    // Reference: decimal digits of the value by plain arithmetic.
    function automatic logic [15:0] model_bcd(input int v);
        int d;
`ifdef BCD_SATURATE_EN
        if (v > 9999) return 16'h9999;
`endif
        d = v % 10000;
        return {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    function automatic logic model_ovf(input int v);
`ifdef BCD_SATURATE_EN
        return v > 9999;
`else
        return (v < 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One full conversion: handshake, latency and busy checks, result, hold.
    task automatic convert(input int v, input logic [15:0] eb, input logic eo, input string name);
        int n;
        bit bad;
        n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        in_valid = 1'b1;
        bin_in   = IN_W'(v);
        tick();
        in_valid = 1'b0;
        bin_in   = IN_W'($urandom);   // must not disturb the running conversion
        n   = 0;
        bad = 1'b0;
        while (!out_valid && n < 40) begin
            if (in_ready || !busy) bad = 1'b1;
            tick();
            n++;
        end
        check({name, " latency"}, n, 15);
        check({name, " busy/ready during"}, {31'd0, bad}, 0);
        check({name, " bcd"}, {16'd0, bcd}, {16'd0, eb});
        check({name, " ovf"}, {31'd0, ovf}, {31'd0, eo});
        check({name, " ready at pulse"}, {31'd0, in_ready}, 1);
        tick();
        check({name, " pulse width"}, {31'd0, out_valid}, 0);
        check({name, " hold"}, {16'd0, bcd}, {16'd0, eb});
    endtask

    vec_t vecs[10];

    initial begin
        int n, t1, t2, pulses, v;

        reset    = 1'b1;
        in_valid = 1'b0;
        bin_in   = '0;

        vecs[0] = '{0,     16'h0000, 1'b0};
        vecs[1] = '{1234,  16'h1234, 1'b0};
        vecs[2] = '{9999,  16'h9999, 1'b0};
        vecs[3] = '{1,     16'h0001, 1'b0};
        vecs[4] = '{10,    16'h0010, 1'b0};
        vecs[5] = '{99,    16'h0099, 1'b0};
        vecs[6] = '{1000,  16'h1000, 1'b0};
        vecs[7] = '{8191,  16'h8191, 1'b0};
`ifdef BCD_SATURATE_EN
        vecs[8] = '{16383, 16'h9999, 1'b1};
        vecs[9] = '{10000, 16'h9999, 1'b1};
`else
        vecs[8] = '{16383, 16'h6383, 1'b0};
        vecs[9] = '{10000, 16'h0000, 1'b0};
`endif

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("reset in_ready", {31'd0, in_ready}, 1);
        check("reset busy", {31'd0, busy}, 0);
        check("reset out_valid", {31'd0, out_valid}, 0);
        check("reset bcd", {16'd0, bcd}, 0);
        check("reset ovf", {31'd0, ovf}, 0);

        // Directed table
        foreach (vecs[i])
            convert(vecs[i].val, vecs[i].exp_bcd, vecs[i].exp_ovf, $sformatf("vec%0d(%0d)", i, vecs[i].val));

        // Random values against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            v = int'($urandom_range(0, 16383));
            convert(v, model_bcd(v), model_ovf(v), $sformatf("rnd(%0d)", v));
        end

        // Back-to-back: 42 then 987 with in_valid held high
        in_valid = 1'b1;
        bin_in   = IN_W'(42);
        tick();
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        t1 = cyc;
        check("b2b first bcd", {16'd0, bcd}, 32'h0042);
        bin_in = IN_W'(987);
        tick();
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        t2 = cyc;
        in_valid = 1'b0;
        check("b2b second bcd", {16'd0, bcd}, 32'h0987);
        check("b2b spacing", t2 - t1, 16);
        tick();

        // in_valid pulsed while busy is ignored
        in_valid = 1'b1;
        bin_in   = IN_W'(500);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        in_valid = 1'b1;
        bin_in   = IN_W'(777);
        tick();
        in_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) pulses++;
            tick();
        end
        check("busy ignore pulses", pulses, 1);
        check("busy ignore bcd", {16'd0, bcd}, 32'h0500);

        // Reset mid-conversion aborts
        in_valid = 1'b1;
        bin_in   = IN_W'(4321);
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort bcd", {16'd0, bcd}, 0);
        check("abort out_valid", {31'd0, out_valid}, 0);
        check("abort in_ready", {31'd0, in_ready}, 1);
        check("abort busy", {31'd0, busy}, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) pulses++;
            tick();
        end
        check("abort no pulse", pulses, 0);
        convert(55, 16'h0055, 1'b0, "after abort 55");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
